// File: rtl/mesm6_alu_ctl_if.sv
// Decoder-side command and response channels of mesm6_alu_ctl.
// The master modport is the decoder; the slave modport is the ALU control block.
interface mesm6_alu_ctl_if #(
    parameter int ALU_OP_WIDTH = 5
);
    logic                    req_valid;
    logic                    req_ready;
    logic [ALU_OP_WIDTH-1:0] req_op;
    logic [47:0]             req_a;
    logic [47:0]             req_b;
    logic                    req_wy;
    logic                    req_grp_log;
    logic                    req_norm;
    logic                    req_round;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [47:0]             rsp_acc;
    logic                    rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_wy, req_grp_log, req_norm, req_round,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_acc, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_wy, req_grp_log, req_norm, req_round,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_acc, rsp_err
    );
endinterface

// File: rtl/mesm6_alu_ctl.sv
// Issuing side of the MESM-6 ALU handshake: one command in flight, result returned on a response channel.
// Build macro MESM6_ALU_TIMEOUT_EN adds a BUSY watchdog that aborts after TIMEOUT_CYCLES cycles.
module mesm6_alu_ctl #(
    parameter int                      ALU_OP_WIDTH   = 5,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_NOP        = '0,
    parameter int                      TIMEOUT_CYCLES = 128
) (
    input  logic                    clk,
    input  logic                    reset_n,
    mesm6_alu_ctl_if.slave          bus,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    alu_wy,
    output logic                    alu_grp_log,
    output logic                    alu_do_norm,
    output logic                    alu_do_round,
    output logic [47:0]             alu_a,
    output logic [47:0]             alu_b,
    input  logic [47:0]             alu_acc,
    input  logic                    alu_done
);

    if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 4..1023");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_YWR,
        S_BUSY,
        S_RESP
    } state_t;

    state_t      r_state;
    logic        r_rsp_valid;
    logic [47:0] r_rsp_acc;
    logic        w_req_ready;
    logic        w_accept;

`ifdef MESM6_ALU_TIMEOUT_EN
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);
    logic [9:0] r_tmo_cnt;
    logic       r_rsp_err;
`endif

    // A done left over from an interrupted operation must clear before a new command goes out.
    assign w_req_ready = (r_state == S_IDLE) && !alu_done;
    assign w_accept    = bus.req_valid && w_req_ready;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_acc   = r_rsp_acc;
`ifdef MESM6_ALU_TIMEOUT_EN
    assign bus.rsp_err   = r_rsp_err;
`else
    assign bus.rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            alu_op       <= ALU_NOP;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_wy       <= 1'b0;
            alu_grp_log  <= 1'b0;
            alu_do_norm  <= 1'b0;
            alu_do_round <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_acc    <= '0;
`ifdef MESM6_ALU_TIMEOUT_EN
            r_rsp_err    <= 1'b0;
            r_tmo_cnt    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        alu_a <= bus.req_a;
                        if (bus.req_op == ALU_NOP) begin
                            // Y-write: the ALU samples Y while the op stays NOP for one cycle.
                            alu_wy  <= bus.req_wy;
                            r_state <= S_YWR;
                        end else begin
                            alu_op       <= bus.req_op;
                            alu_b        <= bus.req_b;
                            alu_wy       <= 1'b0;
                            alu_grp_log  <= bus.req_grp_log;
                            alu_do_norm  <= bus.req_norm;
                            alu_do_round <= bus.req_round;
`ifdef MESM6_ALU_TIMEOUT_EN
                            r_tmo_cnt    <= '0;
`endif
                            r_state      <= S_BUSY;
                        end
                    end
                end
                S_YWR: begin
                    alu_wy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_BUSY: begin
                    if (alu_done) begin
                        r_rsp_acc   <= alu_acc;
                        r_rsp_valid <= 1'b1;
                        alu_op      <= ALU_NOP;
`ifdef MESM6_ALU_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= S_RESP;
                    end
`ifdef MESM6_ALU_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        r_rsp_acc   <= '0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        alu_op      <= ALU_NOP;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 10'd1;
                    end
`endif
                end
                S_RESP: begin
                    // At least one RESP cycle with op=NOP lets the ALU drop done before the next op.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mesm6_alu_ctl.sv
// Bench for mesm6_alu_ctl: behavioural ALU, scoreboard of expected responses, decoupled response monitor.
`timescale 1ns/1ps
module tb_mesm6_alu_ctl;

    localparam int OPW = 5;
    localparam int TO  = 16;

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_AND    = 5'd1;
    localparam logic [4:0] OP_OR     = 5'd2;
    localparam logic [4:0] OP_XOR    = 5'd3;
    localparam logic [4:0] OP_SHIFT  = 5'd4;
    localparam logic [4:0] OP_PACK   = 5'd5;
    localparam logic [4:0] OP_UNPACK = 5'd6;
    localparam logic [4:0] OP_YTA    = 5'd7;
    localparam logic [4:0] OP_ARX    = 5'd8;
    localparam logic [4:0] OP_ACX    = 5'd9;
    localparam logic [4:0] OP_ANX    = 5'd10;
    localparam logic [4:0] OP_FMUL   = 5'd11;

    typedef struct packed {
        logic [47:0] acc;
        logic        err;
        int          e0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  alu_op;
    logic        alu_wy, alu_grp_log, alu_do_norm, alu_do_round;
    logic [47:0] alu_a, alu_b;
    logic [47:0] alu_acc  = '0;
    logic        alu_done = 1'b0;
    logic [47:0] alu_y    = '0;
    int          alu_cnt  = 0;

    int          n_cmp    = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rdy_mode = 0;
    bit          seen     = 0;
    logic [47:0] y_model  = '0;

    mesm6_alu_ctl_if #(.ALU_OP_WIDTH(OPW)) bus ();

    mesm6_alu_ctl #(
        .ALU_OP_WIDTH  (OPW),
        .ALU_NOP       (OP_NOP),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .alu_op      (alu_op),
        .alu_wy      (alu_wy),
        .alu_grp_log (alu_grp_log),
        .alu_do_norm (alu_do_norm),
        .alu_do_round(alu_do_round),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_acc     (alu_acc),
        .alu_done    (alu_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input logic [4:0] op);
        if (op >= OP_AND && op <= OP_YTA) return 1;
        if (op >= OP_ARX && op <= OP_ANX) return 2;
        return 0;
    endfunction

    // Stand-in ALU arithmetic; mode bits fold into the top bits so their routing is observable.
    function automatic logic [47:0] ref_fn(input logic [4:0] op, input logic [47:0] a, input logic [47:0] b,
                                           input logic [47:0] y, input logic g, input logic n, input logic r);
        logic [48:0] s;
        logic [47:0] res;
        s = {1'b0, a} + {1'b0, b};
        case (op)
            OP_AND:    res = a & b;
            OP_OR:     res = a | b;
            OP_XOR:    res = a ^ b;
            OP_SHIFT:  res = a >> b[5:0];
            OP_PACK:   res = {a[23:0], b[23:0]};
            OP_UNPACK: res = {b[23:0], a[47:24]};
            OP_YTA:    res = y;
            OP_ARX:    res = s[47:0] + 48'(s[48]);
            OP_ACX:    res = a - b;
            OP_ANX:    res = ~(a & b);
            default:   res = '0;
        endcase
        return res ^ {g, n, r, 45'd0};
    endfunction

    // Behavioural mesm6_alu: done after k cycles of a held op, cleared by a NOP cycle.
    always @(posedge clk) begin
        if (alu_op == OP_NOP) begin
            alu_done <= 1'b0;
            alu_cnt  <= 0;
            if (alu_wy) alu_y <= alu_a;
        end else if (!alu_done) begin
            alu_cnt <= alu_cnt + 1;
            if (lat_of(alu_op) == alu_cnt + 1) begin
                alu_done <= 1'b1;
                alu_acc  <= ref_fn(alu_op, alu_a, alu_b, alu_y, alu_grp_log, alu_do_norm, alu_do_round);
            end
        end
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.rsp_ready = 1'b1;
                1:       bus.rsp_ready = 1'($urandom_range(0, 1));
                default: bus.rsp_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (reset_n && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL spurious_rsp: rsp_valid=1 acc=%h with no command outstanding", bus.rsp_acc);
            end else begin
                if (!seen) begin
                    chk("rsp_latency", 48'(cyc - sb[0].e0), 48'(sb[0].lat));
                    seen = 1;
                end
                chk("rsp_acc", bus.rsp_acc, sb[0].acc);
                chk("rsp_err", 48'(bus.rsp_err), 48'(sb[0].err));
                chk("alu_op_in_resp", 48'(alu_op), 48'(OP_NOP));
                chk("req_ready_in_resp", 48'(bus.req_ready), 48'd0);
                if (bus.rsp_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [4:0] op, input logic [47:0] a, input logic [47:0] b,
                         input logic wy, input logic g, input logic n, input logic r,
                         input logic use_exp, input logic [47:0] exp_acc, output int e0);
        exp_t e;
        int   w;
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = op;
        bus.req_a       = a;
        bus.req_b       = b;
        bus.req_wy      = wy;
        bus.req_grp_log = g;
        bus.req_norm    = n;
        bus.req_round   = r;
        w = 0;
        while (!bus.req_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_wait: req_ready=0 after %0d cycles, required 1", w);
            bus.req_valid = 1'b0;
            e0 = -1;
            return;
        end
        e0 = cyc + 1;
        if (op == OP_NOP) begin
            if (wy) y_model = a;
        end else begin
            e.e0 = e0;
            if (lat_of(op) == 0) begin
                e.acc = '0;
                e.err = 1'b1;
                e.lat = TO;
            end else begin
                e.acc = use_exp ? exp_acc : ref_fn(op, a, b, y_model, g, n, r);
                e.err = 1'b0;
                e.lat = lat_of(op) + 1;
            end
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        if (op == OP_NOP) begin
            chk("ywr_wy", 48'(alu_wy), 48'(wy));
            chk("ywr_a", alu_a, a);
            chk("ywr_op", 48'(alu_op), 48'(OP_NOP));
            @(posedge clk);
            #1;
            chk("ywr_wy_clear", 48'(alu_wy), 48'd0);
        end else begin
            chk("op_latch", 48'(alu_op), 48'(op));
            chk("a_latch", alu_a, a);
            chk("b_latch", alu_b, b);
            chk("wy_low", 48'(alu_wy), 48'd0);
            chk("mode_latch", 48'({alu_grp_log, alu_do_norm, alu_do_round}), 48'({g, n, r}));
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() > 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int e_a, e_b, w;
        logic [4:0] op;
        bus.req_valid   = 1'b0;
        bus.req_op      = OP_NOP;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.req_wy      = 1'b0;
        bus.req_grp_log = 1'b0;
        bus.req_norm    = 1'b0;
        bus.req_round   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu_op", 48'(alu_op), 48'(OP_NOP));
        chk("rst_alu_a", alu_a, '0);
        chk("rst_alu_b", alu_b, '0);
        chk("rst_rsp_acc", bus.rsp_acc, '0);
        chk("rst_modes", 48'({alu_wy, alu_grp_log, alu_do_norm, alu_do_round}), 48'd0);
        chk("rst_rsp_valid", 48'(bus.rsp_valid), 48'd0);
        chk("rst_rsp_err", 48'(bus.rsp_err), 48'd0);
        chk("rst_req_ready", 48'(bus.req_ready), 48'd1);
        #1 reset_n = 1'b1;

        // Directed checks from the test plan, with literal expected results.
        issue(OP_AND, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 0, 0, 0, 0, 1, 48'h0F0F00000F0F, e_a);
        issue(OP_AND, 48'h123456789ABC, 48'hFFFFFFFFFFFF, 0, 0, 0, 0, 1, 48'h123456789ABC, e_b);
        chk("cadence_single_cycle_op", 48'(e_b - e_a), 48'd4);
        issue(OP_ARX, 48'hFFFFFFFFFFFF, 48'd1, 0, 0, 0, 0, 1, 48'd1, e_a);
        issue(OP_NOP, 48'h123456789ABC, 48'hAAAAAAAAAAAA, 1, 0, 0, 0, 0, '0, e_a);
        issue(OP_YTA, 48'd0, 48'd0, 0, 0, 0, 0, 1, 48'h123456789ABC, e_b);
        chk("cadence_ywrite", 48'(e_b - e_a), 48'd2);
        drain();

        // Response stalled for 5 cycles; the monitor checks stability on every stalled cycle.
        rdy_mode = 2;
        issue(OP_XOR, 48'hF0F0F0F0F0F0, 48'h0FF00FF00FF0, 0, 0, 0, 0, 1, 48'hFF00FF00FF00, e_a);
        w = 0;
        while (!bus.rsp_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("stall_rsp_valid", 48'(bus.rsp_valid), 48'd1);
        repeat (5) @(negedge clk);
        chk("stall_rsp_acc", bus.rsp_acc, 48'hFF00FF00FF00);
        chk("stall_alu_op", 48'(alu_op), 48'(OP_NOP));
        rdy_mode = 0;
        drain();
        issue(OP_OR, 48'h000000FF0000, 48'h00000000FF00, 0, 0, 0, 0, 1, 48'h000000FFFF00, e_a);
        issue(OP_AND, 48'hFFFFFFFFFFFF, 48'h00000000000F, 0, 0, 0, 0, 1, 48'h00000000000F, e_b);
        chk("cadence_after_stall", 48'(e_b - e_a), 48'd4);
        drain();

`ifdef MESM6_ALU_TIMEOUT_EN
        issue(OP_FMUL, 48'h400000000001, 48'h400000000002, 0, 0, 0, 0, 0, '0, e_a);
        drain();
        issue(OP_AND, 48'hFFFF0000FFFF, 48'h0F0F0F0F0F0F, 0, 0, 0, 0, 1, 48'h0F0F00000F0F, e_a);
        drain();
`endif

        // Asynchronous reset while the ALU holds done for an ARX.
        issue(OP_ARX, 48'h000000000010, 48'h000000000020, 0, 0, 0, 0, 1, 48'h000000000030, e_a);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_done", 48'(alu_done), 48'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_alu_op", 48'(alu_op), 48'(OP_NOP));
        chk("arst_alu_a", alu_a, '0);
        chk("arst_alu_b", alu_b, '0);
        chk("arst_rsp_valid", 48'(bus.rsp_valid), 48'd0);
        chk("arst_rsp_acc", bus.rsp_acc, '0);
        chk("arst_req_ready", 48'(bus.req_ready), 48'd0);
        #1 reset_n = 1'b1;
        sb.delete();
        seen = 0;
        #1;
        chk("stale_done_blocks", 48'(bus.req_ready), 48'd0);
        @(posedge clk);
        #1;
        chk("stale_done_cleared", 48'(alu_done), 48'd0);
        chk("ready_after_clear", 48'(bus.req_ready), 48'd1);

        // Randomised commands with random response back-pressure.
        rdy_mode = 1;
        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 10));
            issue(op, {16'($urandom), $urandom}, {16'($urandom), $urandom},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, '0, e_a);
        end
        rdy_mode = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mesm6_alu_ctl.md
# mesm6_alu_ctl

Issuing side of the MESM-6 ALU handshake: accepts one arithmetic/logic command at a time from the instruction decoder over a valid/ready channel and drives `mesm6_alu` op/operand/mode inputs. It waits for `done`, captures the result, and returns the ALU to `ALU_NOP` so its `done` and state clear. It then presents the result on a valid/ready response channel. Sits in the control unit between decode/execute sequencing and `mesm6_alu`.

## Interface
- `TIMEOUT_CYCLES`, default 128: BUSY cycles allowed before abort (only with `MESM6_ALU_TIMEOUT_EN`); legal range 4..1023.

- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: decoder command valid.
- `req_ready` out 1: command accepted on the edge where valid && ready.
- `req_op` in `ALU_OP_WIDTH`: ALU operation code.
- `req_a`, `req_b` in 48 each: operands A and B.
- `req_wy`, `req_grp_log`, `req_norm`, `req_round` in 1 each: Y-write, logical group, normalization enable, rounding enable.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: result consumed on the edge where valid && ready.
- `rsp_acc` out 48: captured ALU result.
- `rsp_err` out 1: operation aborted by timeout.
- `alu_op` out `ALU_OP_WIDTH`: registered op to the ALU.
- `alu_wy`, `alu_grp_log`, `alu_do_norm`, `alu_do_round` out 1 each: registered ALU mode inputs.
- `alu_a`, `alu_b` out 48 each: registered operands.
- `alu_acc` in 48: ALU result.
- `alu_done` in 1: ALU finished.

## Operation
- States: IDLE, YWR, BUSY, RESP.
- `req_ready` = (state==IDLE) && !`alu_done`. A stale `done`, for example after a reset mid-operation, blocks acceptance until the ALU clears it.
- IDLE, accept with `req_op`==`ALU_NOP` (Y-write):
  - latch `alu_a`=`req_a` and `alu_wy`=`req_wy`; `alu_op` stays `ALU_NOP`;
  - go to YWR; no response is generated.
- YWR: `alu_wy`<=0, go to IDLE. The ALU samples Y during this one cycle.
- IDLE, accept with any other op:
  - latch operands, mode bits and `alu_op`=`req_op`; `alu_wy`<=0;
  - clear the timeout counter; go to BUSY.
- BUSY:
  - `alu_op` and operands are held stable;
  - on `alu_done`: `rsp_acc`<=`alu_acc`, `rsp_err`<=0, `rsp_valid`<=1, `alu_op`<=`ALU_NOP`, go to RESP.
- RESP:
  - `alu_op`=`ALU_NOP`; the ALU clears `done` at the first RESP edge;
  - `rsp_acc`/`rsp_err` are held;
  - on `rsp_ready`: `rsp_valid`<=0, go to IDLE.
  - RESP always lasts at least one cycle, which guarantees the mandatory NOP cycle between ALU operations.
- Operands and mode bits are registered copies only; no arithmetic is done in this block.

## Timing
- Reset values:
  - `alu_op`=`ALU_NOP`; `alu_a`/`alu_b`/`rsp_acc` = 0;
  - `alu_wy`/`alu_grp_log`/`alu_do_norm`/`alu_do_round`/`rsp_valid`/`rsp_err` = 0;
  - state IDLE.
- Reset is asynchronous and takes effect mid-BUSY: `alu_op` goes to NOP immediately, and the ALU resets its state on its next edge.
- Latency, with accept at edge E0 and an ALU op that takes k cycles (k=1 for AND/OR/XOR/SHIFT/PACK/UNPACK/YTA, k=2 for ARX/ACX/ANX):
  - `alu_done` rises after E_k;
  - `rsp_valid` rises after E_{k+1};
  - earliest next accept is at E_{k+3} when `rsp_ready` is held high.
  - Throughput for single-cycle ops: one per 4 cycles.
- Y-write occupies 2 cycles (accept edge, YWR edge).
- `alu_done` and `rsp_ready` in the same cycle have no interaction: they are in different states.

## Configuration
- `MESM6_ALU_TIMEOUT_EN` defined:
  - a 10-bit counter increments on every BUSY cycle without `alu_done`;
  - when it equals `TIMEOUT_CYCLES`-1 with no `done`, go to RESP with `rsp_err`=1, `rsp_acc`=0, `alu_op`<=NOP;
  - `rsp_valid` rises after E_{TIMEOUT_CYCLES};
  - `alu_done` on the same edge takes priority and gives a normal result.
  - This covers the unimplemented FMUL/FDIV ops, which never finish.
- Undefined: no counter; BUSY waits indefinitely; `rsp_err` is tied to 0.

## Test plan
- AND, a=48'hFFFF0000FFFF, b=48'h0F0F0F0F0F0F -> `rsp_acc`=48'h0F0F00000F0F, `rsp_valid` 2 cycles after accept, `alu_op` back to NOP the same edge.
- ARX, a=48'hFFFFFFFFFFFF, b=1 -> `rsp_acc`=1 (end-around carry), `rsp_valid` 3 cycles after accept.
- Y-write via NOP with `req_wy`=1, a=48'h123456789ABC, then YTA -> no response for the first command; `rsp_acc`=48'h123456789ABC for the second.
- `rsp_ready` low for 5 cycles in RESP -> `rsp_valid`/`rsp_acc` stable, `req_ready`=0, `alu_op`=NOP throughout; back-to-back accept restores the 4-cycle cadence.
- With `MESM6_ALU_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, issue FMUL -> `rsp_valid`=1 with `rsp_err`=1 and `rsp_acc`=0 after edge E16. A following AND completes normally with `rsp_err`=0.
- Assert `reset_n`=0 mid-ARX, release while the ALU model still holds `done`=1 -> `req_ready` stays 0 until `alu_done` falls; all outputs are at reset values.
